apb_ucpd_tx_sched: RTL and testbench
====================================

Name: apb_ucpd_tx_sched

Overview:
Transmit scheduler for the UCPD core. Arbitrates three transmit requesters (hard reset, cable reset, normal message) onto the core's shared transmit controls: transmit_en, tx_hrst and tx_mode. It enforces the interframe gap and line-idle, tracks completion and discard, retries discarded messages and times out hung transfers. It sits between the register block and the UCPD core, in the ic_clk domain.

Parameters:
TMO_W, 16, width of the transfer timeout counter
TMO_MAX, 16'd60000, ic_clk cycles allowed in SEND before abort
RETRY_MAX, 2, re-attempts of a discarded normal message (0..3)

Ports:
ic_clk  in  1  UCPD kernel clock
ic_rst_n  in  1  reset; synchronous, active-low
ucpden  in  1  block enable; low = synchronous abort to IDLE
hrst_req  in  1  hard-reset request (level, held until done/disc)
crst_req  in  1  cable-reset request (level)
msg_req  in  1  normal-message request (level)
rx_busy  in  1  receiver not idle (line activity)
ifrgap_en  in  1  interframe gap elapsed (level from clock generator)
txsend_clr  in  1  core pulse: message/cable reset sent
txhrst_clr  in  1  core pulse: hard reset sent
tx_msg_disc  in  1  core pulse: message discarded
tx_hrst_disc  in  1  core pulse: hard reset discarded
transmit_en  out  1  one-cycle start pulse to core
tx_hrst  out  1  one-cycle hard-reset start pulse to core
tx_mode  out  2  00 normal, 01 cable reset; held from ARM until IDLE
done  out  3  one-cycle completion pulse per requester {msg,crst,hrst}
disc  out  3  one-cycle failure pulse per requester {msg,crst,hrst}
busy  out  1  scheduler not IDLE
tmo_err  out  1  one-cycle pulse on timeout
owner  out  2  current grant: 0 none, 1 hrst, 2 crst, 3 msg

Behaviour:
- Reset (ic_rst_n low at a clock edge): state IDLE; every output 0, including tx_mode=00 and owner=0; retry count 0; timeout counter 0.
- States: IDLE, GAP, ARM, SEND, DONE.
- IDLE: if any request is asserted, grant it by fixed priority hrst > crst > msg. Set owner and go to GAP next cycle.
- GAP: wait until ifrgap_en=1 and rx_busy=0, then go to ARM.
  - hrst owner ignores rx_busy.
  - If the owner's request drops, return to IDLE with no pulse.
  - If hrst_req rises while crst or msg owns, change owner to hrst and stay in GAP.
- ARM: exactly one cycle.
  - hrst owner: tx_hrst=1.
  - Otherwise: transmit_en=1, tx_mode=01 for crst and 00 for msg.
  - Clear the timeout counter, then go to SEND.
- SEND: the timeout counter increments every cycle.
  - txsend_clr (crst/msg) or txhrst_clr (hrst): go to DONE.
  - tx_msg_disc with msg owner: if retries < RETRY_MAX, increment retries and go to GAP. Otherwise pulse disc[2] and go to IDLE.
  - tx_hrst_disc with hrst owner: pulse disc[0] and go to IDLE.
  - hrst_req rising during a msg or crst SEND: pulse disc for the current owner, set owner=hrst, go to ARM; the core discards the in-flight frame.
  - Counter reaches TMO_MAX: pulse tmo_err and disc[owner], go to IDLE.
  - Completion and timeout in the same cycle: completion wins.
- DONE: one cycle. Pulse done[owner], clear retries, go to IDLE with owner=0. Requests are ignored in this cycle; requesters deassert on the done/disc pulse.
- ucpden=0: in any state, next cycle is IDLE with all outputs and counters at reset values and no done/disc pulses.
- tx_mode resets to 00 on return to IDLE.
- Retry and timeout counters saturate; they never wrap.

Optional Feature:
UCPD_TX_SCHED_RR_EN
- Defined: crst and msg arbitrate round-robin. The one served last (done or disc) loses the next tie. hrst always remains highest.
- Undefined: fixed priority hrst > crst > msg.

Test Plan:
- msg_req=1, ifrgap_en=1, rx_busy=0 -> owner=3 then GAP, one-cycle transmit_en with tx_mode=00 at cycle 3; txsend_clr 10 cycles later -> done=3'b100 for one cycle, then busy=0.
- msg_req and crst_req asserted together, fixed priority -> crst served first (tx_mode=01, done=3'b010), then msg (done=3'b100). With UCPD_TX_SCHED_RR_EN and crst served last -> msg served first.
- msg in SEND, tx_msg_disc pulsed 3 times with RETRY_MAX=2 -> 3 transmit_en pulses total, then disc=3'b100, no done.
- msg in SEND, hrst_req rises -> disc=3'b100 next cycle, tx_hrst pulse, owner=1; txhrst_clr -> done=3'b001.
- crst granted, rx_busy=1 held 50 cycles -> no transmit_en; rx_busy falls -> transmit_en within 2 cycles. Then no completion for TMO_MAX cycles -> tmo_err and disc=3'b010.
- ucpden dropped mid-SEND, and separately ic_rst_n low for one cycle -> all outputs 0 and state IDLE on the next edge; no done/disc pulses.

Source files
------------

// File: rtl/apb_ucpd_tx_sched.sv
// UCPD transmit scheduler: arbitrates hard reset, cable reset and normal
// message requests onto the core transmit controls. It handles the
// interframe gap and line idle, completion and discard, message retry and
// the transfer timeout.
// Optional build macro UCPD_TX_SCHED_RR_EN: round-robin between crst and msg
// on a tie (hrst always wins). Undefined: fixed priority hrst > crst > msg.
module apb_ucpd_tx_sched #(
  parameter int unsigned           TMO_W     = 16,
  parameter logic [TMO_W-1:0]      TMO_MAX   = 16'd60000,
  parameter int unsigned           RETRY_MAX = 2
) (
  input  logic       ic_clk,
  input  logic       ic_rst_n,
  input  logic       ucpden,
  input  logic       hrst_req,
  input  logic       crst_req,
  input  logic       msg_req,
  input  logic       rx_busy,
  input  logic       ifrgap_en,
  input  logic       txsend_clr,
  input  logic       txhrst_clr,
  input  logic       tx_msg_disc,
  input  logic       tx_hrst_disc,
  output logic       transmit_en,
  output logic       tx_hrst,
  output logic [1:0] tx_mode,
  output logic [2:0] done,
  output logic [2:0] disc,
  output logic       busy,
  output logic       tmo_err,
  output logic [1:0] owner
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_ARM, S_SEND, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_HRST = 2'd1,
                            OWN_CRST = 2'd2, OWN_MSG  = 2'd3} own_t;

  localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_MAX - TMO_ONE;
  localparam logic [1:0]       RETRY_LIM = RETRY_MAX[1:0];

  state_t           state_q, state_d;
  own_t             own_q, own_d, grant;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       retry_q, retry_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       disc_q, disc_d;
  logic             tmo_err_q, tmo_err_d;
  logic             own_req, fail;

  function automatic logic [2:0] own_bit(input own_t o);
    case (o)
      OWN_HRST: own_bit = 3'b001;
      OWN_CRST: own_bit = 3'b010;
      OWN_MSG:  own_bit = 3'b100;
      default:  own_bit = 3'b000;
    endcase
  endfunction

`ifdef UCPD_TX_SCHED_RR_EN
  logic last_msg_q, last_msg_d;

  // Remember which of crst/msg finished last (done or disc) for the tie-break.
  always_comb begin
    last_msg_d = last_msg_q;
    if (ucpden && (own_q == OWN_CRST || own_q == OWN_MSG) &&
        (state_q == S_DONE || disc_d != 3'b000))
      last_msg_d = (own_q == OWN_MSG);
  end

  // Round-robin state register; reset lets crst win the first tie.
  always_ff @(posedge ic_clk) begin
    if (!ic_rst_n) last_msg_q <= 1'b1;
    else           last_msg_q <= last_msg_d;
  end
`endif

  // Request arbitration used when leaving IDLE.
  always_comb begin
    grant = OWN_NONE;
    if (hrst_req)                 grant = OWN_HRST;
`ifdef UCPD_TX_SCHED_RR_EN
    else if (crst_req && msg_req) grant = last_msg_q ? OWN_CRST : OWN_MSG;
`endif
    else if (crst_req)            grant = OWN_CRST;
    else if (msg_req)             grant = OWN_MSG;
  end

  // Next-state, grant, counters and registered pulse outputs.
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    mode_d    = mode_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    disc_d    = 3'b000;
    tmo_err_d = 1'b0;
    fail      = 1'b0;
    case (own_q)
      OWN_HRST: own_req = hrst_req;
      OWN_CRST: own_req = crst_req;
      OWN_MSG:  own_req = msg_req;
      default:  own_req = 1'b0;
    endcase
    if (!ucpden) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmo_d = '0;
          if (grant != OWN_NONE) begin
            own_d   = grant;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (hrst_req && own_q != OWN_HRST) own_d = OWN_HRST;
          else if (!own_req)                 state_d = S_IDLE;
          else if (ifrgap_en && (!rx_busy || own_q == OWN_HRST)) begin
            state_d = S_ARM;
            mode_d  = (own_q == OWN_CRST) ? 2'b01 : 2'b00;
          end
        end
        S_ARM: begin
          tmo_d   = '0;
          state_d = S_SEND;
        end
        S_SEND: begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_ONE;
          if ((own_q == OWN_HRST && txhrst_clr) || (own_q != OWN_HRST && txsend_clr))
            state_d = S_DONE;
          else if (own_q == OWN_MSG && tx_msg_disc) begin
            if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + 2'd1;
              state_d = S_GAP;
            end else fail = 1'b1;
          end
          else if (own_q == OWN_HRST && tx_hrst_disc) fail = 1'b1;
          // Level-sensitive so a hard reset raised during ARM still preempts.
          else if (own_q != OWN_HRST && hrst_req) begin
            disc_d  = own_bit(own_q);
            own_d   = OWN_HRST;
            mode_d  = 2'b00;
            state_d = S_ARM;
          end
          else if (tmo_q >= TMO_LAST) begin
            tmo_err_d = 1'b1;
            fail      = 1'b1;
          end
          if (fail) begin
            disc_d  = own_bit(own_q);
            state_d = S_IDLE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Every entry to IDLE drops the grant, mode and retry history.
    if (state_d == S_IDLE) begin
      own_d   = (state_q == S_IDLE && ucpden) ? own_d : OWN_NONE;
      mode_d  = 2'b00;
      retry_d = 2'd0;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge ic_clk) begin
    if (!ic_rst_n) begin
      state_q   <= S_IDLE;
      own_q     <= OWN_NONE;
      mode_q    <= 2'b00;
      retry_q   <= 2'd0;
      tmo_q     <= '0;
      disc_q    <= 3'b000;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      mode_q    <= mode_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      disc_q    <= disc_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Start pulses and completion are decoded from the current state.
  always_comb begin
    transmit_en = (state_q == S_ARM) && (own_q != OWN_HRST);
    tx_hrst     = (state_q == S_ARM) && (own_q == OWN_HRST);
    done        = (state_q == S_DONE) ? own_bit(own_q) : 3'b000;
    disc        = disc_q;
    busy        = (state_q != S_IDLE);
    tmo_err     = tmo_err_q;
    owner       = own_q;
    tx_mode     = mode_q;
  end

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Self-checking bench for apb_ucpd_tx_sched: directed scenarios plus random
// request/response transactions scored against a transaction-level model.
module tb_apb_ucpd_tx_sched;
  localparam int unsigned TMO  = 300;
  localparam int unsigned RMAX = 2;

  logic ic_clk = 1'b0;
  logic ic_rst_n, ucpden, hrst_req, crst_req, msg_req, rx_busy, ifrgap_en;
  logic txsend_clr, txhrst_clr, tx_msg_disc, tx_hrst_disc;
  logic transmit_en, tx_hrst, busy, tmo_err;
  logic [1:0] tx_mode, owner;
  logic [2:0] done, disc;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_msg = 1'b1;   // model: msg was served last (so crst wins a tie)

  always #5 ic_clk = ~ic_clk;

  apb_ucpd_tx_sched #(.TMO_W(16), .TMO_MAX(16'(TMO)), .RETRY_MAX(RMAX)) dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden),
    .hrst_req(hrst_req), .crst_req(crst_req), .msg_req(msg_req),
    .rx_busy(rx_busy), .ifrgap_en(ifrgap_en),
    .txsend_clr(txsend_clr), .txhrst_clr(txhrst_clr),
    .tx_msg_disc(tx_msg_disc), .tx_hrst_disc(tx_hrst_disc),
    .transmit_en(transmit_en), .tx_hrst(tx_hrst), .tx_mode(tx_mode),
    .done(done), .disc(disc), .busy(busy), .tmo_err(tmo_err), .owner(owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] all_outs();
    return {transmit_en, tx_hrst, tx_mode, done, disc, busy, tmo_err, owner};
  endfunction

  // Arbitration rule: hrst first; crst/msg tie by priority or round-robin.
  function automatic int pick(bit h, bit c, bit m);
    if (h) return 1;
`ifdef UCPD_TX_SCHED_RR_EN
    if (c && m) return last_msg ? 2 : 3;
`endif
    if (c) return 2;
    if (m) return 3;
    return 0;
  endfunction

  function automatic logic [2:0] bit_of(int o);
    return (o == 1) ? 3'b001 : (o == 2) ? 3'b010 : (o == 3) ? 3'b100 : 3'b000;
  endfunction

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ic_clk);
      seen = transmit_en | tx_hrst;
    end
  endtask

  task automatic drop_req(input int who);
    if (who == 1) hrst_req = 1'b0;
    if (who == 2) begin crst_req = 1'b0; last_msg = 1'b0; end
    if (who == 3) begin msg_req  = 1'b0; last_msg = 1'b1; end
  endtask

  // Serve the requester the model expects to win; nd_h/nd_m are the number
  // of discards the fake core reports before completing.
  task automatic serve_one(input int nd_h, input int nd_m);
    int exp, nd, attempt, k, gap_left, busy_left;
    bit finished, seen, allowed;
    logic [2:0] exp_done, exp_disc;
    exp = pick(hrst_req, crst_req, msg_req);
    k = 0;
    while (owner == 2'd0 && k < 4) begin @(negedge ic_clk); k++; end
    check("grant_owner", owner, exp);
    nd = (exp == 3) ? nd_m : (exp == 1) ? nd_h : 0;
    attempt = 0; finished = 1'b0; exp_done = '0; exp_disc = '0;
    while (!finished) begin
      gap_left = $urandom_range(0, 3);
      busy_left = $urandom_range(0, 5);
      seen = 1'b0; k = 0;
      while (!seen && k < 12) begin
        ifrgap_en = (gap_left == 0);
        rx_busy   = (busy_left != 0);
        allowed   = (gap_left == 0) && (busy_left == 0 || exp == 1);
        @(negedge ic_clk); k++;
        seen = transmit_en | tx_hrst;
        check("start_when_allowed", seen, allowed);
        if (gap_left > 0) gap_left--;
        if (busy_left > 0) busy_left--;
      end
      ifrgap_en = 1'b1; rx_busy = 1'b0;
      check("start_seen", seen, 1);
      if (!seen) begin
        hrst_req = 0; crst_req = 0; msg_req = 0;
        return;
      end
      check("start_kind", {tx_hrst, transmit_en}, (exp == 1) ? 2'b10 : 2'b01);
      check("start_mode", tx_mode, (exp == 2) ? 2'd1 : 2'd0);
      repeat ($urandom_range(1, 5)) begin
        @(negedge ic_clk);
        check("send_quiet", {done, disc, tmo_err, transmit_en, tx_hrst}, 0);
      end
      if (attempt < nd) begin
        if (exp == 3) tx_msg_disc = 1'b1; else tx_hrst_disc = 1'b1;
      end else if (exp == 1) txhrst_clr = 1'b1;
      else txsend_clr = 1'b1;
      @(negedge ic_clk);
      {tx_msg_disc, tx_hrst_disc, txsend_clr, txhrst_clr} = '0;
      exp_done = '0; exp_disc = '0;
      if (attempt >= nd) begin exp_done = bit_of(exp); finished = 1'b1; end
      else if (exp == 3 && attempt < RMAX) attempt++;
      else begin exp_disc = bit_of(exp); finished = 1'b1; end
      check("result_done", done, exp_done);
      check("result_disc", disc, exp_disc);
    end
    drop_req(exp);
    if (exp_done != 3'b000) @(negedge ic_clk);
    check("back_idle", {busy, owner, tx_mode}, 0);
  endtask

  initial begin
    bit s;
    int n;
    ic_rst_n = 0; ucpden = 1; hrst_req = 0; crst_req = 0; msg_req = 0;
    rx_busy = 0; ifrgap_en = 1;
    {txsend_clr, txhrst_clr, tx_msg_disc, tx_hrst_disc} = '0;
    repeat (3) @(negedge ic_clk);
    check("reset_outputs", all_outs(), 0);
    ic_rst_n = 1;
    @(negedge ic_clk);
    check("idle_after_reset", all_outs(), 0);

    // crst and msg together: model decides the order
    crst_req = 1; msg_req = 1;
    serve_one(0, 0);
    serve_one(0, 0);

    // msg preempted by hard reset during SEND
    msg_req = 1;
    wait_start(s);
    check("pre_start", s, 1);
    @(negedge ic_clk);
    hrst_req = 1;
    @(negedge ic_clk);
    check("pre_disc", disc, 3'b100);
    check("pre_hrst_pulse", {tx_hrst, transmit_en}, 2'b10);
    check("pre_owner", owner, 1);
    drop_req(3);
    @(negedge ic_clk);
    txhrst_clr = 1;
    @(negedge ic_clk);
    txhrst_clr = 0;
    check("pre_done", done, 3'b001);
    hrst_req = 0;
    @(negedge ic_clk);
    check("pre_idle", {busy, owner}, 0);

    // crst held off by rx_busy, then left to time out
    crst_req = 1; rx_busy = 1;
    n = 0;
    repeat (50) begin
      @(negedge ic_clk);
      if (transmit_en) n++;
    end
    check("busy_hold_no_start", n, 0);
    check("busy_hold_owner", owner, 2);
    rx_busy = 0;
    s = 0;
    for (int i = 0; i < 2 && !s; i++) begin @(negedge ic_clk); s = transmit_en; end
    check("start_after_busy", s, 1);
    n = 0;
    while (!tmo_err && n < TMO + 10) begin @(negedge ic_clk); n++; end
    check("tmo_latency", n, TMO + 1);
    check("tmo_disc", disc, 3'b010);
    check("tmo_no_done", done, 0);
    drop_req(2);
    @(negedge ic_clk);
    check("tmo_idle", all_outs(), 0);

    // ucpden dropped mid-SEND
    msg_req = 1;
    wait_start(s);
    check("abort_start", s, 1);
    @(negedge ic_clk);
    ucpden = 0;
    @(negedge ic_clk);
    check("abort_outputs", all_outs(), 0);
    @(negedge ic_clk);
    check("abort_no_grant", all_outs(), 0);
    msg_req = 0; ucpden = 1;
    @(negedge ic_clk);

    // random transactions
    for (int t = 0; t < 30; t++) begin
      int mask;
      mask = $urandom_range(1, 7);
      hrst_req = mask[0]; crst_req = mask[1]; msg_req = mask[2];
      while (hrst_req || crst_req || msg_req)
        serve_one($urandom_range(0, 1), $urandom_range(0, 3));
      @(negedge ic_clk);
    end

    // reset pulse mid-SEND of a cable reset
    crst_req = 1;
    wait_start(s);
    check("rst_start", s, 1);
    check("rst_mode_crst", tx_mode, 2'b01);
    @(negedge ic_clk);
    ic_rst_n = 0;
    @(negedge ic_clk);
    check("rst_mid_outputs", all_outs(), 0);
    ic_rst_n = 1; crst_req = 0; last_msg = 1;
    @(negedge ic_clk);
    check("rst_mid_idle", all_outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
